tpu_rstation_mq: RTL and testbench

- Multi-queue coprocessor reservation station between the CPU cop request channel and the TPU execution units.
- Decodes each accepted cop instruction into one of three parametrised in-order issue queues (LOAD, TMMA, STORE) and issues each queue's head independently.
- Answers status and illegal instructions on the cop response channel.
- Successor of the single-TMMA-queue station: adds configurable depth and widths, load/store queues, status reporting and optional load-before-tmma ordering.

---
 rtl/tpu_rstation_mq.sv | 187 ++++++++++++++++++
 tb/tb_tpu_rstation_mq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_rstation_mq.sv
// tpu_rstation_mq: coprocessor reservation station with three in-order issue
// queues (LOAD, TMMA, STORE) and a single-entry cop response register.
// Optional feature macro TPU_RS_ORDER_EN: TMMA entries wait until every LOAD
// that was queued ahead of them has issued.
module tpu_rstation_mq #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned AW    = 64,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CFG_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_tpu_req_vld_i,
  output logic                 cpu_tpu_req_rdy_o,
  input  logic [31:0]          cpu_tpu_req_insn_i,
  input  logic [XLEN-1:0]      cpu_tpu_req_rs1_data_i,
  input  logic [XLEN-1:0]      cpu_tpu_req_rs2_data_i,
  input  logic [XLEN-1:0]      cpu_tpu_req_rs3_data_i,
  output logic                 cpu_tpu_resp_vld_o,
  input  logic                 cpu_tpu_resp_rdy_i,
  output logic [XLEN-1:0]      cpu_tpu_resp_data_o,
  output logic [2:0]           issue_valid_o,
  input  logic [2:0]           issue_ready_i,
  output logic [8:0]           issue_type_o,
  output logic [3*AW-1:0]      issue_addr0_o,
  output logic [3*AW-1:0]      issue_addr1_o,
  output logic [3*CFG_W-1:0]   issue_cfg_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned NQ = 3;

  typedef enum logic [2:0] {
    F_TLOAD      = 3'd0,
    F_PRELOADC   = 3'd1,
    F_TMMA       = 3'd2,
    F_POSTSTOREC = 3'd3,
    F_PRELOADA   = 3'd4,
    F_TSTORE     = 3'd5,
    F_ILLEGAL    = 3'd6,
    F_TSTAT      = 3'd7
  } func3_e;

  func3_e           f3;
  logic [NQ-1:0]    tgt;
  logic             is_rsp;
  logic [NQ-1:0]    full;
  logic [NQ-1:0]    empty;
  logic [NQ-1:0]    head_ok;
  logic [NQ-1:0]    push;
  logic [NQ-1:0]    pop;
  logic [NQ*CW-1:0] cnt_all;
  logic             req_hs;
  logic             rsp_load;
  logic             resp_vld_q;
  logic [XLEN-1:0]  resp_data_q;
  logic [XLEN-1:0]  stat_data;
  logic [7:0]       ld_cnt8, tm_cnt8, st_cnt8;

  // Decode func3 into a one-hot target queue or a response-only instruction
  always_comb begin
    f3     = func3_e'(cpu_tpu_req_insn_i[14:12]);
    tgt    = '0;
    is_rsp = 1'b0;
    case (f3)
      F_TLOAD:                                      tgt = 3'b001;
      F_PRELOADC, F_TMMA, F_POSTSTOREC, F_PRELOADA: tgt = 3'b010;
      F_TSTORE:                                     tgt = 3'b100;
      default:                                      is_rsp = 1'b1;
    endcase
  end

  // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot early
  assign cpu_tpu_req_rdy_o = is_rsp ? ~resp_vld_q : |(tgt & ~full);
  assign req_hs            = cpu_tpu_req_vld_i & cpu_tpu_req_rdy_o;
  assign push              = tgt & {NQ{req_hs}};
  assign rsp_load          = req_hs & is_rsp;
  assign pop               = issue_valid_o & issue_ready_i;

  for (genvar q = 0; q < NQ; q++) begin : g_q
    logic [2:0]       typ_mem [DEPTH];
    logic [AW-1:0]    a0_mem  [DEPTH];
    logic [AW-1:0]    a1_mem  [DEPTH];
    logic [CFG_W-1:0] cfg_mem [DEPTH];
    logic [CW-1:0]    wr_q, rd_q, cnt_q;
    logic [PW-1:0]    wa, ra;

    assign wa       = wr_q[PW-1:0];
    assign ra       = rd_q[PW-1:0];
    assign full[q]  = (wa == ra) && (wr_q[PW] != rd_q[PW]);
    assign empty[q] = (wr_q == rd_q);
    assign cnt_all[q*CW +: CW] = cnt_q;

    // Pointer (index plus wrap bit) and occupancy count maintenance
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push[q]) wr_q <= wr_q + 1'b1;
        if (pop[q])  rd_q <= rd_q + 1'b1;
        cnt_q <= cnt_q + CW'(push[q]) - CW'(pop[q]);
      end
    end

    // Entry storage written on push; contents only matter while occupied
    always_ff @(posedge clk) begin
      if (push[q]) begin
        typ_mem[wa] <= cpu_tpu_req_insn_i[14:12];
        a0_mem[wa]  <= cpu_tpu_req_rs1_data_i[AW-1:0];
        a1_mem[wa]  <= cpu_tpu_req_rs2_data_i[AW-1:0];
        cfg_mem[wa] <= cpu_tpu_req_rs3_data_i[CFG_W-1:0];
      end
    end

    assign issue_valid_o[q]            = ~empty[q] & head_ok[q];
    assign issue_type_o[3*q +: 3]      = typ_mem[ra];
    assign issue_addr0_o[q*AW +: AW]   = a0_mem[ra];
    assign issue_addr1_o[q*AW +: AW]   = a1_mem[ra];
    assign issue_cfg_o[q*CFG_W +: CFG_W] = cfg_mem[ra];

`ifdef TPU_RS_ORDER_EN
    if (q == 1) begin : g_ord
      logic [CW-1:0] la_mem [DEPTH];
      logic [CW-1:0] la_push;

      // A LOAD leaving in the push cycle is already accounted for here
      assign la_push = cnt_all[0 +: CW] - CW'(pop[0]);

      // Track LOADs still ahead of each TMMA entry; unoccupied slots may
      // decrement harmlessly because a push overwrites them
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < DEPTH; i++) la_mem[i] <= '0;
        end else begin
          for (int unsigned i = 0; i < DEPTH; i++) begin
            if (push[1] && (wa == PW'(i)))
              la_mem[i] <= la_push;
            else if (pop[0] && (la_mem[i] != '0))
              la_mem[i] <= la_mem[i] - 1'b1;
          end
        end
      end

      assign head_ok[q] = (la_mem[ra] == '0);
    end else begin : g_no_ord
      assign head_ok[q] = 1'b1;
    end
`else
    assign head_ok[q] = 1'b1;
`endif
  end

  assign ld_cnt8   = 8'(cnt_all[0*CW +: CW]);
  assign tm_cnt8   = 8'(cnt_all[1*CW +: CW]);
  assign st_cnt8   = 8'(cnt_all[2*CW +: CW]);
  assign stat_data = XLEN'({st_cnt8, tm_cnt8, ld_cnt8});

  // Single-entry response register: loaded on TSTAT/illegal accept, freed on resp handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_vld_q  <= 1'b0;
      resp_data_q <= '0;
    end else if (rsp_load) begin
      resp_vld_q  <= 1'b1;
      resp_data_q <= (f3 == F_TSTAT) ? stat_data : '1;
    end else if (resp_vld_q && cpu_tpu_resp_rdy_i) begin
      resp_vld_q  <= 1'b0;
    end
  end

  assign cpu_tpu_resp_vld_o  = resp_vld_q;
  assign cpu_tpu_resp_data_o = resp_data_q;

  logic unused_req_bits;
  assign unused_req_bits = ^{cpu_tpu_req_insn_i[31:15], cpu_tpu_req_insn_i[11:0],
                             cpu_tpu_req_rs3_data_i[XLEN-1:CFG_W]};

  if (AW < XLEN) begin : g_addr_trunc
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_tpu_req_rs1_data_i[XLEN-1:AW],
                                cpu_tpu_req_rs2_data_i[XLEN-1:AW]};
  end

endmodule

// File: tb/tb_tpu_rstation_mq.sv
// Directed bench for tpu_rstation_mq (DEPTH=4, 64-bit widths).
module tb_tpu_rstation_mq;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned AW    = 64;
  localparam int unsigned CFG_W = 8;

  logic              clk;
  logic              rst_n;
  logic              req_vld;
  logic              req_rdy;
  logic [31:0]       insn;
  logic [XLEN-1:0]   rs1, rs2, rs3;
  logic              resp_vld;
  logic              resp_rdy;
  logic [XLEN-1:0]   resp_data;
  logic [2:0]        iss_vld;
  logic [2:0]        iss_rdy;
  logic [8:0]        iss_type;
  logic [3*AW-1:0]   iss_a0;
  logic [3*AW-1:0]   iss_a1;
  logic [3*CFG_W-1:0] iss_cfg;

  int total = 0;
  int bad   = 0;

  tpu_rstation_mq #(.XLEN(XLEN), .AW(AW), .DEPTH(4), .CFG_W(CFG_W)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .cpu_tpu_req_vld_i      (req_vld),
    .cpu_tpu_req_rdy_o      (req_rdy),
    .cpu_tpu_req_insn_i     (insn),
    .cpu_tpu_req_rs1_data_i (rs1),
    .cpu_tpu_req_rs2_data_i (rs2),
    .cpu_tpu_req_rs3_data_i (rs3),
    .cpu_tpu_resp_vld_o     (resp_vld),
    .cpu_tpu_resp_rdy_i     (resp_rdy),
    .cpu_tpu_resp_data_o    (resp_data),
    .issue_valid_o          (iss_vld),
    .issue_ready_i          (iss_rdy),
    .issue_type_o           (iss_type),
    .issue_addr0_o          (iss_a0),
    .issue_addr1_o          (iss_a1),
    .issue_cfg_o            (iss_cfg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_f3(input logic [2:0] f);
    insn = 32'h0;
    insn[14:12] = f;
  endtask

  task automatic push(input logic [2:0] f, input logic [63:0] a0,
                      input logic [63:0] a1, input logic [63:0] c);
    req_vld = 1'b1;
    set_f3(f);
    rs1 = a0;
    rs2 = a1;
    rs3 = c;
    #1;
    chk("push_rdy", {63'd0, req_rdy}, 64'd1);
    cycle();
    req_vld = 1'b0;
  endtask

  task automatic drain_resp();
    resp_rdy = 1'b1;
    cycle();
    resp_rdy = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_vld = 1'b0; insn = '0; rs1 = '0; rs2 = '0; rs3 = '0;
    resp_rdy = 1'b0; iss_rdy = 3'b000;

    // reset state
    #2;
    chk("rst_valid", {61'd0, iss_vld}, 64'd0);
    chk("rst_resp_vld", {63'd0, resp_vld}, 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_req_rdy", {63'd0, req_rdy}, 64'd1);
    #10 rst_n = 1'b1;
    cycle();

    // single TLOAD, held while not ready
    push(3'd0, 64'h1000, 64'h2000, 64'h5);
    chk("ld_valid", {61'd0, iss_vld}, 64'b001);
    chk("ld_type", {61'd0, iss_type[2:0]}, 64'd0);
    chk("ld_addr0", iss_a0[0 +: AW], 64'h1000);
    chk("ld_addr1", iss_a1[0 +: AW], 64'h2000);
    chk("ld_cfg", {56'd0, iss_cfg[0 +: CFG_W]}, 64'h05);
    cycle(); cycle();
    chk("ld_hold_valid", {61'd0, iss_vld}, 64'b001);
    chk("ld_hold_addr0", iss_a0[0 +: AW], 64'h1000);
    iss_rdy = 3'b001;
    cycle();
    iss_rdy = 3'b000;
    chk("ld_popped", {61'd0, iss_vld}, 64'd0);

    // fill TMMA queue, check full/ready behaviour
    for (int i = 0; i < 4; i++) push(3'd2, 64'h10 + 64'(i), 64'h0, 64'h0);
    set_f3(3'd2); #1;
    chk("tm_full_rdy", {63'd0, req_rdy}, 64'd0);
    set_f3(3'd0); #1;
    chk("ld_rdy_while_tm_full", {63'd0, req_rdy}, 64'd1);
    set_f3(3'd2);
    iss_rdy = 3'b010; #1;
    chk("no_passthru_rdy", {63'd0, req_rdy}, 64'd0);
    chk("tm_head0", iss_a0[AW +: AW], 64'h10);
    cycle();
    iss_rdy = 3'b000; #1;
    chk("tm_rdy_back", {63'd0, req_rdy}, 64'd1);
    chk("tm_head1", iss_a0[AW +: AW], 64'h11);

    // stream through pointer wraps with simultaneous push/pop
    iss_rdy = 3'b010;
    for (int k = 0; k < 12; k++) begin
      req_vld = 1'b1; set_f3(3'd2); rs1 = 64'h14 + 64'(k);
      #1;
      chk("wrap_head", iss_a0[AW +: AW], 64'h11 + 64'(k));
      chk("wrap_rdy", {63'd0, req_rdy}, 64'd1);
      cycle();
    end
    req_vld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("drain_head", iss_a0[AW +: AW], 64'h1D + 64'(k));
      chk("drain_vld", {63'd0, iss_vld[1]}, 64'd1);
      cycle();
    end
    chk("tm_empty", {63'd0, iss_vld[1]}, 64'd0);
    iss_rdy = 3'b000;

    // TSTAT with LOAD=2, TMMA=3
    push(3'd0, 64'hA0, 64'h0, 64'h0);
    push(3'd0, 64'hA1, 64'h0, 64'h0);
    push(3'd1, 64'hB0, 64'h0, 64'h0);
    push(3'd3, 64'hB1, 64'h0, 64'h0);
    push(3'd4, 64'hB2, 64'h0, 64'h0);
    chk("tm_type", {61'd0, iss_type[5:3]}, 64'd1);
    push(3'd7, 64'h0, 64'h0, 64'h0);
    chk("stat_vld", {63'd0, resp_vld}, 64'd1);
    chk("stat_data", resp_data, 64'h302);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("stat_hold", resp_data, 64'h302);
    end
    chk("stat_hold_vld", {63'd0, resp_vld}, 64'd1);
    req_vld = 1'b1; set_f3(3'd7); #1;
    chk("stat2_rdy", {63'd0, req_rdy}, 64'd0);
    req_vld = 1'b0;
    drain_resp();
    chk("stat_freed", {63'd0, resp_vld}, 64'd0);

    // illegal func3
    push(3'd6, 64'h0, 64'h0, 64'h0);
    chk("ill_vld", {63'd0, resp_vld}, 64'd1);
    chk("ill_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("ill_no_push", {61'd0, iss_vld}, 64'b011);
    drain_resp();
    push(3'd7, 64'h0, 64'h0, 64'h0);
    chk("ill_counts", resp_data, 64'h302);
    drain_resp();

    // simultaneous push/pop on LOAD at count 2
    iss_rdy = 3'b001;
    push(3'd0, 64'hA2, 64'h0, 64'h0);
    iss_rdy = 3'b000;
    chk("pp_head", iss_a0[0 +: AW], 64'hA1);
    push(3'd7, 64'h0, 64'h0, 64'h0);
    chk("pp_count", resp_data, 64'h302);
    drain_resp();

    // asynchronous reset mid-burst with a pending response
    push(3'd6, 64'h0, 64'h0, 64'h0);
    req_vld = 1'b1; set_f3(3'd0); rs1 = 64'hC0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", {61'd0, iss_vld}, 64'd0);
    chk("arst_resp_vld", {63'd0, resp_vld}, 64'd0);
    chk("arst_resp_data", resp_data, 64'd0);
    req_vld = 1'b0;
    #3 rst_n = 1'b1;
    cycle();
    chk("post_rst_valid", {61'd0, iss_vld}, 64'd0);
    chk("post_rst_rdy", {63'd0, req_rdy}, 64'd1);

    // load-before-tmma ordering
    iss_rdy = 3'b110;
    push(3'd0, 64'hD0, 64'h0, 64'h0);
    push(3'd0, 64'hD1, 64'h0, 64'h0);
    push(3'd2, 64'hE0, 64'h0, 64'h0);
`ifdef TPU_RS_ORDER_EN
    chk("ord_blocked0", {63'd0, iss_vld[1]}, 64'd0);
    cycle();
    chk("ord_blocked1", {63'd0, iss_vld[1]}, 64'd0);
    iss_rdy = 3'b111;
    cycle();
    chk("ord_after_ld1", {63'd0, iss_vld[1]}, 64'd0);
    chk("ord_ld2_vld", {63'd0, iss_vld[0]}, 64'd1);
    cycle();
    chk("ord_tm_vld", {63'd0, iss_vld[1]}, 64'd1);
    chk("ord_tm_addr", iss_a0[AW +: AW], 64'hE0);
    cycle();
    chk("ord_all_done", {61'd0, iss_vld}, 64'd0);
`else
    chk("noord_tm_vld", {63'd0, iss_vld[1]}, 64'd1);
    chk("noord_tm_addr", iss_a0[AW +: AW], 64'hE0);
    chk("noord_ld_vld", {63'd0, iss_vld[0]}, 64'd1);
    cycle();
    chk("noord_tm_gone", {63'd0, iss_vld[1]}, 64'd0);
    iss_rdy = 3'b111;
    cycle(); cycle();
    chk("noord_all_done", {61'd0, iss_vld}, 64'd0);
`endif
    iss_rdy = 3'b000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
